// File: rtl/ml_l3_trig_ctrl.sv
// Shutter-trigger controller for ml_l3_pulse_gen: debounces the release key and
// issues single-cycle trig strobes, either one per press or as a timed interval series.
module ml_l3_trig_ctrl #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned MIN_GAP_MS  = 100
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       mode,
  input  logic [7:0] interval_s,
  input  logic [7:0] shots,
  output logic       trig,
  output logic       busy,
  output logic [7:0] shot_cnt
);

  localparam logic [63:0] DB_CYC  = 64'(DEBOUNCE_MS) * 64'(CLK_FREQ) / 64'd1000;
  localparam logic [63:0] GAP_CYC = 64'(MIN_GAP_MS) * 64'(CLK_FREQ) / 64'd1000;
  localparam logic [63:0] IVL_MAX = 64'd255 * 64'(CLK_FREQ);

  localparam int DB_W  = $clog2(DB_CYC + 64'd1);
  localparam int CNT_W = $clog2(IVL_MAX + 64'd1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYC - 64'd1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CLK_CNT = CNT_W'(CLK_FREQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic             key_lvl_q, key_lvl_d;
  logic [DB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;

  logic [1:0]       state_q, state_d;
  logic             trig_q, trig_d;
  logic [7:0]       shot_cnt_q, shot_cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             abort_q, abort_d;
  logic             mode_q, mode_d;
  logic [7:0]       shots_q, shots_d;
  logic [CNT_W-1:0] ivl_cyc_q, ivl_cyc_d;
  logic [7:0]       ivl_eff;

  // The debounce counter only runs while the synced level disagrees with the
  // accepted level, so any bounce back to the accepted level restarts it.
  always_comb begin
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
    key_lvl_d  = key_lvl_q;
    deb_cnt_d  = '0;
    press_d    = 1'b0;
    if (key_sync_q != key_lvl_q) begin
      if (deb_cnt_q == DB_LAST) begin
        key_lvl_d = key_sync_q;
        press_d   = ~key_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DB_W'(1);
      end
    end
  end

  assign ivl_eff = (interval_s == 8'd0) ? 8'd1 : interval_s;

  // tmr is zero in the trig cycle, so GAP and WAIT both measure from the strobe.
  always_comb begin
    state_d    = state_q;
    trig_d     = 1'b0;
    shot_cnt_d = shot_cnt_q;
    tmr_d      = tmr_q + CNT_W'(1);
    abort_d    = abort_q | press_q;
    mode_d     = mode_q;
    shots_d    = shots_q;
    ivl_cyc_d  = ivl_cyc_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        tmr_d   = '0;
        if (press_q) begin
          state_d    = FIRE;
          trig_d     = 1'b1;
          mode_d     = mode;
          shots_d    = shots;
          ivl_cyc_d  = CNT_W'(ivl_eff) * CLK_CNT;
          shot_cnt_d = 8'd1;
        end
      end
      FIRE: state_d = GAP;
      GAP: begin
        if (tmr_q == GAP_END) begin
          if (abort_d || !mode_q || (shots_q != 8'd0 && shot_cnt_q == shots_q)) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort_d) begin
          state_d = IDLE;
        end else if (tmr_q >= ivl_cyc_q - CNT_W'(1)) begin
          state_d    = FIRE;
          trig_d     = 1'b1;
          shot_cnt_d = shot_cnt_q + 8'd1;
          tmr_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_lvl_q  <= 1'b1;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      shot_cnt_q <= 8'd0;
      tmr_q      <= '0;
      abort_q    <= 1'b0;
      mode_q     <= 1'b0;
      shots_q    <= 8'd0;
      ivl_cyc_q  <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_lvl_q  <= key_lvl_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      trig_q     <= trig_d;
      shot_cnt_q <= shot_cnt_d;
      tmr_q      <= tmr_d;
      abort_q    <= abort_d;
      mode_q     <= mode_d;
      shots_q    <= shots_d;
      ivl_cyc_q  <= ivl_cyc_d;
    end
  end

  assign trig     = trig_q;
  assign busy     = (state_q != IDLE);
  assign shot_cnt = shot_cnt_q;

endmodule

// File: tb/tb_ml_l3_trig_ctrl.sv
// Scoreboard bench for ml_l3_trig_ctrl at CLK_FREQ=1000: the stimulus side predicts
// each run's strobe schedule, a negedge monitor pops and compares every trig.
module tb_ml_l3_trig_ctrl;

  localparam int SEC     = 1000;
  localparam int GAP     = 100;
  localparam int LAT_MIN = 21;
  localparam int LAT_MAX = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] interval_s = 8'd1;
  logic [7:0] shots = 8'd1;
  logic       trig;
  logic       busy;
  logic [7:0] shot_cnt;

  typedef struct {
    bit first;
    int offset;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   press_cyc = 0;
  int   t0 = -1;
  int   last_trig = -1;
  int   trig_seen = 0;
  int   busy_run = 0;
  int   last_busy_len = 0;
  bit   prev_trig = 1'b0;

  ml_l3_trig_ctrl #(
    .CLK_FREQ(1000),
    .DEBOUNCE_MS(20),
    .MIN_GAP_MS(100)
  ) dut (
    .clk_50M(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .mode(mode),
    .interval_s(interval_s),
    .shots(shots),
    .trig(trig),
    .busy(busy),
    .shot_cnt(shot_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (trig) begin
      trig_seen++;
      checkOutput("trig_width", !prev_trig, int'(prev_trig), 0);
      checkOutput("busy_at_trig", busy, int'(busy), 1);
      if (last_trig >= 0)
        checkOutput("trig_spacing", (cyc - last_trig) >= GAP, cyc - last_trig, GAP);
      last_trig = cyc;
      if (sb.size() == 0) begin
        checkOutput("unexpected_trig", 1'b0, cyc, -1);
      end else begin
        e = sb.pop_front();
        if (e.first) begin
          checkOutput("press_latency", (cyc - press_cyc) >= LAT_MIN && (cyc - press_cyc) <= LAT_MAX,
                      cyc - press_cyc, 23);
          t0 = cyc;
        end else begin
          checkOutput("trig_time", t0 >= 0 && cyc == t0 + e.offset, cyc - t0, e.offset);
        end
        checkOutput("shot_cnt_at_trig", int'(shot_cnt) == e.cnt, int'(shot_cnt), e.cnt);
      end
    end
    prev_trig = trig;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pressKey(input int bounces);
    @(negedge clk);
    repeat (bounces) begin
      key_n = 1'b0;
      waitCycles(3);
      key_n = 1'b1;
      waitCycles(3);
    end
    key_n = 1'b0;
    press_cyc = cyc;
    waitCycles(25);
    key_n = 1'b1;
    waitCycles(2);
    key_n = 1'b0;
    waitCycles(2);
    key_n = 1'b1;
    waitCycles(25);
  endtask

  // Model: strobes at k*period from the first; an abort press cancels every
  // strobe scheduled after its accepted press (2 sync + 20 stable + 1 cycle).
  task automatic applyStimulus(input bit m, input int ivl, input int sh, input int abort_x,
                               input bit scramble, input int bounces);
    int per, nmax, abort_off, ntrig, last_off, exp_len, budget, off;
    mode       = m;
    interval_s = 8'(ivl);
    shots      = 8'(sh);
    per        = ((ivl == 0) ? 1 : ivl) * SEC;
    nmax       = (m == 1'b0) ? 1 : ((sh == 0) ? 1000 : sh);
    abort_off  = (abort_x >= 0) ? abort_x + 23 : -1;
    ntrig      = 0;
    last_off   = 0;
    for (int k = 0; k < nmax; k++) begin
      off = k * per;
      if (abort_off >= 0 && off > abort_off) break;
      sb.push_back('{k == 0, off, (k + 1) % 256});
      ntrig++;
      last_off = off;
    end
    exp_len = (abort_off < 0 || last_off + GAP + 1 > abort_off) ? last_off + GAP + 1 : -1;
    t0 = -1;
    pressKey(bounces);
    if (scramble) begin
      mode       = 1'($urandom);
      interval_s = 8'($urandom);
      shots      = 8'($urandom);
    end
    if (abort_x >= 0) begin
      checkOutput("first_trig_seen", t0 >= 0, t0, 0);
      if (t0 >= 0) begin
        while (cyc < t0 + abort_x) waitCycles(1);
        pressKey(0);
      end
    end
    budget = last_off + 3000;
    while ((sb.size() != 0 || busy) && budget > 0) begin
      waitCycles(1);
      budget--;
    end
    checkOutput("run_done", budget > 0, sb.size(), 0);
    sb.delete();
    waitCycles(2);
    checkOutput("shot_cnt_end", int'(shot_cnt) == ntrig % 256, int'(shot_cnt), ntrig % 256);
    if (exp_len >= 0)
      checkOutput("busy_len", last_busy_len == exp_len, last_busy_len, exp_len);
    waitCycles(40);
  endtask

  initial begin
    int prior;
    waitCycles(3);
    checkOutput("reset_trig", trig == 1'b0, int'(trig), 0);
    checkOutput("reset_busy", busy == 1'b0, int'(busy), 0);
    checkOutput("reset_shot_cnt", shot_cnt == 8'd0, int'(shot_cnt), 0);
    rst_n = 1'b1;
    waitCycles(40);

    $display("[TB] single shot with bouncing key");
    applyStimulus(1'b0, 1, 1, -1, 1'b0, 5);
    $display("[TB] interval run, 2 s, 3 shots");
    applyStimulus(1'b1, 2, 3, -1, 1'b0, 2);
    $display("[TB] unlimited run aborted in WAIT");
    applyStimulus(1'b1, 0, 0, 1500, 1'b0, 3);
    $display("[TB] unlimited run aborted in GAP");
    applyStimulus(1'b1, 1, 0, 60, 1'b0, 1);
    $display("[TB] inputs changed during a run");
    applyStimulus(1'b1, 1, 2, -1, 1'b1, 2);

    $display("[TB] reset in the middle of WAIT");
    mode = 1'b1;
    interval_s = 8'd1;
    shots = 8'd0;
    sb.push_back('{1'b1, 0, 1});
    t0 = -1;
    pressKey(2);
    checkOutput("reset_run_started", t0 >= 0, t0, 0);
    if (t0 >= 0) while (cyc < t0 + 500) waitCycles(1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_trig", trig == 1'b0, int'(trig), 0);
    checkOutput("async_reset_busy", busy == 1'b0, int'(busy), 0);
    checkOutput("async_reset_shot_cnt", shot_cnt == 8'd0, int'(shot_cnt), 0);
    sb.delete();
    prior = trig_seen;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2500);
    checkOutput("no_trig_after_reset", trig_seen == prior, trig_seen - prior, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 3)), -1, 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
